rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NREQ writeback requesters
//  (e.g. ALU, load unit, multi-cycle unit).
//  - Round-robin arbitration, valid/ready handshake per requester.
//  - One registered stage toward the RF write port.
//  - Raises read-hazard flags when rs1/rs2 hit the staged, not-yet-committed write.

---
 rtl/rf_wb_arbiter_pkg.sv | 21 ++
 rtl/rf_wb_arbiter_if.sv | 27 ++
 rtl/rf_wb_arbiter_rr_arbiter.sv | 54 +++++
 rtl/rf_wb_arbiter.sv | 79 +++++++
 tb/tb_rf_wb_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Register-file writeback types and width defaults shared by the arbiter slice.
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DPATH = 5;

  typedef logic [RF_DPATH-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
    logic     we;
  } rf_wr_t;

  // Index width for an n-way choice; a 1-way choice still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus: NREQ valid/ready requesters packed side by side.
interface rf_wb_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int DPATH = 5
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DPATH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves to the winner on advance.
// Search starts just past the last winner; grant is forced low while rst is high.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [idx_w(N)-1:0]  gnt_idx
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr;
  logic [N-1:0]  upper;
  logic [N-1:0]  masked;
  logic [N-1:0]  sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= gnt_idx;
    end
  end

  // Requesters above the pointer win first; if none, wrap to the lowest index.
  always_comb begin
    upper   = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = (IW'(i) > ptr);
    end
    masked = req & upper;
    sel    = (|masked) ? masked : req;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    if (rst) begin
      gnt     = '0;
      gnt_idx = '0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port among NREQ writeback requesters, round-robin, with hazard flags.
// Latency 1 (transfer -> registered write); one write per cycle, never back-pressured.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DPATH = RF_DPATH,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             rst,
  rf_wb_arbiter_if.slave   req_if,
  input  logic [DPATH-1:0] rs1,
  input  logic [DPATH-1:0] rs2,
  output logic             RegWen,
  output logic [DPATH-1:0] rsW,
  output logic [WIDTH-1:0] dataW,
  output logic             hz1,
  output logic             hz2
);

  localparam int IW = idx_w(NREQ);

  typedef struct packed {
    logic [DPATH-1:0] addr;
    logic [WIDTH-1:0] data;
    logic             we;
  } stage_t;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic             xfer;
  logic [DPATH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;
  stage_t           stage;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_if.req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_if.req_ready = gnt;
  assign xfer             = |(gnt & req_if.req_valid);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr = req_if.req_addr[i*DPATH +: DPATH];
        sel_data = req_if.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // x0 writes are accepted but never enable the RF; idle cycles keep addr/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (xfer) begin
      stage.addr <= sel_addr;
      stage.data <= sel_data;
      stage.we   <= (sel_addr != '0);
    end else begin
      stage.we   <= 1'b0;
    end
  end

  assign RegWen = stage.we;
  assign rsW    = stage.addr;
  assign dataW  = stage.data;
  assign hz1    = stage.we && (stage.addr == rs1) && (rs1 != '0);
  assign hz2    = stage.we && (stage.addr == rs2) && (rs2 != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected RF writes, a monitor pops them.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic       RegWen;
  logic [4:0] rsW;
  logic [31:0] dataW;
  logic       hz1;
  logic       hz2;

  int passed = 0;
  int total  = 0;
  rf_wr_t exp_q[$];

  rf_wb_arbiter_if #(.NREQ(2), .WIDTH(32), .DPATH(5)) bus ();

  rf_wb_arbiter #(.WIDTH(32), .DPATH(5), .NREQ(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_if (bus),
    .rs1    (rs1),
    .rs2    (rs2),
    .RegWen (RegWen),
    .rsW    (rsW),
    .dataW  (dataW),
    .hz1    (hz1),
    .hz2    (hz2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_bus(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  // One cycle: drive after the edge, check grant at the negedge, record the expected write.
  task automatic cyc(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1,
                     input logic [1:0] exp_rdy, input string nm);
    @(posedge clk);
    #1;
    set_bus(v, a0, d0, a1, d1);
    @(negedge clk);
    chk(nm, bus.req_ready, exp_rdy);
    if (exp_rdy[0] && a0 != 5'd0) exp_q.push_back('{addr: a0, data: d0, we: 1'b1});
    else if (exp_rdy[1] && a1 != 5'd0) exp_q.push_back('{addr: a1, data: d1, we: 1'b1});
  endtask

  always @(negedge clk) begin
    if (!rst && RegWen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", RegWen, 1'b0);
      end else begin
        rf_wr_t e;
        e = exp_q.pop_front();
        chk("rf_write", {rsW, dataW}, {e.addr, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset holds grants and the write port low even with both requesters valid.
    set_bus(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_regwen", RegWen, 1'b0);
    chk("rst_rsw", rsW, 5'd0);
    chk("rst_dataw", dataW, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_first_grant", bus.req_ready, 2'b01);
    exp_q.push_back('{addr: 5'd1, data: 32'h11, we: 1'b1});
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "idle_ready");

    // Single write, then the stage goes idle and holds addr/data.
    cyc(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b01, "single_grant");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "single_idle");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "single_idle2");
    chk("single_regwen_off", RegWen, 1'b0);
    chk("single_rsw_hold", rsW, 5'd5);
    chk("single_dataw_hold", dataW, 32'hDEAD_BEEF);

    // Move the pointer to requester 1 so contention starts with requester 0.
    cyc(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 2'b10, "ptr_to_1");
    for (int k = 0; k < 6; k++) begin
      cyc(2'b11, 5'd3, 32'hA3, 5'd4, 32'hA4, (k % 2 == 0) ? 2'b01 : 2'b10, "contend_grant");
      if (k > 0) chk("contend_regwen", RegWen, 1'b1);
    end

    // x0 write accepted but never enabled, and no hazard on rs1=0.
    rs1 = 5'd0;
    cyc(2'b10, 5'd0, 32'h0, 5'd0, 32'h55, 2'b10, "x0_grant");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "x0_idle");
    chk("x0_regwen", RegWen, 1'b0);
    chk("x0_hz1", hz1, 1'b0);

    // Hazard against the staged write to r7.
    cyc(2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 2'b01, "hz_grant");
    rs1 = 5'd7;
    rs2 = 5'd8;
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "hz_idle");
    chk("hz1_hit", hz1, 1'b1);
    chk("hz2_miss", hz2, 1'b0);
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "hz_idle2");
    chk("hz1_clear", hz1, 1'b0);

    // Asynchronous reset while a write is staged; pointer restarts at requester 0.
    cyc(2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 2'b01, "r6_grant");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "r6_idle");
    chk("r6_regwen_before", RegWen, 1'b1);
    set_bus(2'b11, 5'd10, 32'hA, 5'd11, 32'hB);
    #1 rst = 1'b1;
    #1;
    chk("r6_async_regwen", RegWen, 1'b0);
    chk("r6_rst_ready", bus.req_ready, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("r6_no_write_after_rst", RegWen, 1'b0);
    @(negedge clk);
    chk("r6_ptr_restart", bus.req_ready, 2'b01);
    exp_q.push_back('{addr: 5'd10, data: 32'hA, we: 1'b1});
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "drain");
    cyc(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, "drain2");
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
